// File: rtl/wb_arbiter.sv
// Write-back arbiter for the register file write port.
// ALU results (single cycle, strict priority) are merged with multi-cycle
// results that are buffered in a small FIFO. A 32-bit pending-destination
// scoreboard tells decode which registers still await a multi-cycle write.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [4:0]    alu_rd,
    input  logic [31:0]   alu_data,
    input  logic          ml_valid,
    output logic          ml_ready,
    input  logic [4:0]    ml_rd,
    input  logic [31:0]   ml_data,
    input  logic          iss_valid,
    input  logic [4:0]    iss_rd,
    input  logic [4:0]    chk_rs1,
    input  logic [4:0]    chk_rs2,
    output logic          busy_rs1,
    output logic          busy_rs2,
    output logic          rf_we,
    output logic [4:0]    rf_addr,
    output logic [31:0]   rf_wdata,
    output logic [CW-1:0] fifo_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // FIFO storage and bookkeeping
    logic [4:0]    mem_rd_q   [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    // Write-port and scoreboard state
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_addr_q, rf_addr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic [31:0]   pending_q, pending_d;

    logic          push_s;
    logic          pop_s;
    logic [4:0]    head_rd_s;
    logic [31:0]   head_data_s;

    // Handshake and arbitration decisions; ready depends on occupancy only.
    always_comb begin
        ml_ready    = (count_q < CW'(DEPTH));
        push_s      = ml_valid && ml_ready;
        pop_s       = !alu_valid && (count_q != {CW{1'b0}});
        head_rd_s   = mem_rd_q[rptr_q];
        head_data_s = mem_data_q[rptr_q];
    end

    // Next-state for pointers, occupancy, write port and scoreboard.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        rf_we_d    = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;
        pending_d  = pending_q;

        if (push_s) begin
            wptr_d = wptr_q + PW'(1);
        end else begin
            wptr_d = wptr_q;
        end

        if (pop_s) begin
            rptr_d = rptr_q + PW'(1);
        end else begin
            rptr_d = rptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // ALU wins; a result targeting x0 is consumed without a write.
        if (alu_valid) begin
            rf_we_d    = (alu_rd != 5'd0);
            rf_addr_d  = alu_rd;
            rf_wdata_d = alu_data;
        end else if (pop_s) begin
            rf_we_d    = (head_rd_s != 5'd0);
            rf_addr_d  = head_rd_s;
            rf_wdata_d = head_data_s;
        end else begin
            rf_we_d    = 1'b0;
        end

        // Clear first so that a same-edge issue (newer op) wins.
        if (pop_s) begin
            pending_d[head_rd_s] = 1'b0;
        end else begin
            pending_d = pending_d;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            pending_d[iss_rd] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        pending_d[0] = 1'b0;
    end

    // FIFO entry storage; written only on an accepted push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_rd_q[i]   <= 5'd0;
                mem_data_q[i] <= 32'd0;
            end
        end else if (push_s) begin
            mem_rd_q[wptr_q]   <= ml_rd;
            mem_data_q[wptr_q] <= ml_data;
        end
    end

    // Control state: pointers, occupancy, write port and scoreboard.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= {PW{1'b0}};
            rptr_q     <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            rf_we_q    <= 1'b0;
            rf_addr_q  <= 5'd0;
            rf_wdata_q <= 32'd0;
            pending_q  <= 32'd0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            pending_q  <= pending_d;
        end
    end

    // Output mapping; busy is a direct scoreboard lookup, x0 never busy.
    always_comb begin
        rf_we      = rf_we_q;
        rf_addr    = rf_addr_q;
        rf_wdata   = rf_wdata_q;
        fifo_count = count_q;
        busy_rs1   = (chk_rs1 != 5'd0) && pending_q[chk_rs1];
        busy_rs2   = (chk_rs2 != 5'd0) && pending_q[chk_rs2];
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with hand-computed expectations.
`timescale 1ns/1ps
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ml_valid;
    logic        ml_ready;
    logic [4:0]  ml_rd;
    logic [31:0] ml_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_bad = 0;

    wb_arbiter #(.DEPTH(4), .CW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ml_valid   (ml_valid),
        .ml_ready   (ml_ready),
        .ml_rd      (ml_rd),
        .ml_data    (ml_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .busy_rs1   (busy_rs1),
        .busy_rs2   (busy_rs2),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_wdata   (rf_wdata),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // advance one edge and sample 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ml_valid = 1'b0; ml_rd = 5'd0; ml_data = 32'd0;
        iss_valid = 1'b0; iss_rd = 5'd0; chk_rs1 = 5'd0; chk_rs2 = 5'd0;
        tick(); tick();
        check_eq("rst_we",    {31'd0, rf_we},    32'd0);
        check_eq("rst_addr",  {27'd0, rf_addr},  32'd0);
        check_eq("rst_data",  rf_wdata,          32'd0);
        check_eq("rst_count", {29'd0, fifo_count}, 32'd0);
        check_eq("rst_ready", {31'd0, ml_ready}, 32'd1);
        rst = 1'b1;
        tick();

        // ALU single-cycle write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_0005;
        tick();
        alu_valid = 1'b0;
        check_eq("alu_we",   {31'd0, rf_we},   32'd1);
        check_eq("alu_addr", {27'd0, rf_addr}, 32'd5);
        check_eq("alu_data", rf_wdata,         32'h5);
        tick();
        check_eq("alu_we_drop", {31'd0, rf_we},   32'd0);
        check_eq("alu_addr_hold", {27'd0, rf_addr}, 32'd5);

        // issue rd7, later multi-cycle result for rd7
        iss_valid = 1'b1; iss_rd = 5'd7; chk_rs1 = 5'd7; chk_rs2 = 5'd0;
        tick();
        iss_valid = 1'b0;
        check_eq("busy7_set", {31'd0, busy_rs1}, 32'd1);
        check_eq("busy_x0",   {31'd0, busy_rs2}, 32'd0);
        chk_rs2 = 5'd7;
        #1;
        check_eq("busy7_rs2", {31'd0, busy_rs2}, 32'd1);
        ml_valid = 1'b1; ml_rd = 5'd7; ml_data = 32'hDEAD_BEEF;
        tick();
        ml_valid = 1'b0;
        check_eq("ml_cnt1",     {29'd0, fifo_count}, 32'd1);
        check_eq("ml_busy_hold",{31'd0, busy_rs1},   32'd1);
        check_eq("ml_we_early", {31'd0, rf_we},      32'd0);
        tick();
        check_eq("ml_we",    {31'd0, rf_we},      32'd1);
        check_eq("ml_addr",  {27'd0, rf_addr},    32'd7);
        check_eq("ml_data",  rf_wdata,            32'hDEAD_BEEF);
        check_eq("ml_busy0", {31'd0, busy_rs1},   32'd0);
        check_eq("ml_cnt0",  {29'd0, fifo_count}, 32'd0);

        // ALU starves FIFO for 6 cycles while 5 results are offered
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'h100 + 32'(i);
            ml_valid  = 1'b1;
            ml_rd     = 5'(16 + ((i < 4) ? i : 4));
            ml_data   = 32'hA0 + 32'((i < 4) ? i : 4);
            tick();
            check_eq($sformatf("stv_addr%0d", i), {27'd0, rf_addr}, 32'(10 + i));
            check_eq($sformatf("stv_cnt%0d", i), {29'd0, fifo_count}, 32'((i < 3) ? i + 1 : 4));
            check_eq($sformatf("stv_rdy%0d", i), {31'd0, ml_ready}, (i < 3) ? 32'd1 : 32'd0);
        end
        alu_valid = 1'b0;  // entry 4 still offered
        tick();            // pop entry 0, no push (was full)
        check_eq("drn_addr0", {27'd0, rf_addr}, 32'd16);
        check_eq("drn_data0", rf_wdata,          32'hA0);
        check_eq("drn_cnt0",  {29'd0, fifo_count}, 32'd3);
        tick();            // pop entry 1, push entry 4
        ml_valid = 1'b0;
        check_eq("drn_addr1", {27'd0, rf_addr}, 32'd17);
        check_eq("drn_cnt1",  {29'd0, fifo_count}, 32'd3);
        for (int j = 2; j < 5; j++) begin
            tick();
            check_eq($sformatf("drn_we%0d", j),   {31'd0, rf_we},   32'd1);
            check_eq($sformatf("drn_addr%0d", j), {27'd0, rf_addr}, 32'(16 + j));
            check_eq($sformatf("drn_data%0d", j), rf_wdata,          32'hA0 + 32'(j));
            check_eq($sformatf("drn_cnt%0d", j),  {29'd0, fifo_count}, 32'(4 - j));
        end
        tick();
        check_eq("drn_idle", {31'd0, rf_we}, 32'd0);

        // x0 results: never written, FIFO entry still consumed
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        tick();
        alu_valid = 1'b0;
        check_eq("x0_alu_we", {31'd0, rf_we}, 32'd0);
        ml_valid = 1'b1; ml_rd = 5'd0; ml_data = 32'h55;
        tick();
        ml_valid = 1'b0;
        check_eq("x0_cnt1", {29'd0, fifo_count}, 32'd1);
        check_eq("x0_we_a", {31'd0, rf_we},      32'd0);
        tick();
        check_eq("x0_cnt0", {29'd0, fifo_count}, 32'd0);
        check_eq("x0_we_b", {31'd0, rf_we},      32'd0);
        chk_rs1 = 5'd0;
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        iss_valid = 1'b0;
        check_eq("x0_busy", {31'd0, busy_rs1}, 32'd0);

        // same-edge pop and issue of rd9: set wins
        chk_rs1 = 5'd9;
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        ml_valid = 1'b1; ml_rd = 5'd9; ml_data = 32'h99;
        tick();
        ml_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        check_eq("p9_we",   {31'd0, rf_we},    32'd1);
        check_eq("p9_addr", {27'd0, rf_addr},  32'd9);
        check_eq("p9_busy", {31'd0, busy_rs1}, 32'd1);
        tick();
        check_eq("p9_busy_hold", {31'd0, busy_rs1}, 32'd1);

        // async reset mid-cycle with 3 entries buffered
        iss_valid = 1'b1; iss_rd = 5'd21; chk_rs2 = 5'd21;
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
            ml_valid = 1'b1; ml_rd = 5'(21 + k); ml_data = 32'hC0 + 32'(k);
            tick();
            iss_valid = 1'b0;
        end
        ml_valid = 1'b0;
        check_eq("ar_cnt3",  {29'd0, fifo_count}, 32'd3);
        check_eq("ar_busy21",{31'd0, busy_rs2},   32'd1);
        alu_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_eq("ar_cnt",   {29'd0, fifo_count}, 32'd0);
        check_eq("ar_we",    {31'd0, rf_we},      32'd0);
        check_eq("ar_busy1", {31'd0, busy_rs1},   32'd0);
        check_eq("ar_busy2", {31'd0, busy_rs2},   32'd0);
        check_eq("ar_ready", {31'd0, ml_ready},   32'd1);
        tick();
        rst = 1'b1;
        tick();
        check_eq("ar_post_we", {31'd0, rf_we}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
